// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: datapath widths, writeback source
// select codes and load/store funct3 encodings.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Writeback source select; 2'b11 is reserved and falls back to the ALU.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  // Load funct3 encodings.
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  // Store funct3 encodings.
  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;

endpackage

// File: rtl/mem_wb_stage_wb_mux.sv
// Writeback value select: 3:1 choice between ALU result, load data and
// return address, zeroed for bubbles so stale data is never forwarded.
module wb_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            i_valid,
  input  logic [1:0]      i_sel,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_mem,
  input  logic [XLEN-1:0] i_pc4,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_sel_val;

  // Source select; the reserved code behaves like the ALU path.
  always_comb begin
    w_sel_val = i_alu;
    case (i_sel)
      WB_MEM:  w_sel_val = i_mem;
      WB_PC4:  w_sel_val = i_pc4;
      default: w_sel_val = i_alu;
    endcase
  end

  assign o_data = i_valid ? w_sel_val : '0;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback: drives the register-file write
// port and WB forwarding value, and counts retired instructions.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int INSTRET_W  = 64,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic [XLEN-1:0]       calculated_result,
  input  logic [XLEN-1:0]       read_data,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic [1:0]            wb_sel,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic [INSTRET_W-1:0]  instret
);

  localparam logic [INSTRET_W-1:0] ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  logic                  r_valid;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [1:0]            r_wb_sel;
  logic [XLEN-1:0]       r_calc;
  logic [XLEN-1:0]       r_rdata;
  logic [XLEN-1:0]       r_pc4;
  logic [INSTRET_W-1:0]  r_instret;

  logic [XLEN-1:0]       w_wb_data;

  // MEM/WB capture with flush > stall > advance priority; instret counts the
  // WB instruction on the edge it leaves the stage, so a held one counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= WB_ALU;
      r_calc      <= '0;
      r_rdata     <= '0;
      r_pc4       <= '0;
      r_instret   <= '0;
    end else begin
      if (r_valid && (!stall || flush)) begin
        r_instret <= r_instret + ONE;
      end
      if (flush) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_rd        <= '0;
        r_wb_sel    <= WB_ALU;
        r_calc      <= '0;
        r_rdata     <= '0;
        r_pc4       <= '0;
      end else if (!stall) begin
        r_valid     <= mem_valid;
        r_reg_write <= reg_write;
        r_rd        <= rd_addr;
        r_wb_sel    <= wb_sel;
        r_calc      <= calculated_result;
        r_rdata     <= read_data;
        r_pc4       <= pc_plus4;
      end
    end
  end

  wb_mux #(
    .XLEN (XLEN)
  ) u_wb_mux (
    .i_valid (r_valid),
    .i_sel   (r_wb_sel),
    .i_alu   (r_calc),
    .i_mem   (r_rdata),
    .i_pc4   (r_pc4),
    .o_data  (w_wb_data)
  );

  assign wb_valid = r_valid;
  assign wb_we    = r_valid & r_reg_write & (r_rd != '0);
  assign wb_rd    = r_rd;
  assign wb_data  = w_wb_data;
  assign instret  = r_instret;

`ifndef SYNTHESIS
  // A real instruction must never carry the reserved writeback select.
  a_no_reserved_sel: assert property (@(posedge clk) disable iff (rst)
    r_valid |-> (r_wb_sel != WB_RSVD));
`endif

endmodule
